instr_mem_loader: RTL and testbench

- Boot-time writer for the instruction memory's write port (instr_in / wr_addr / wr_en).
- Receives a little-endian byte stream over a valid/ready handshake.
  - Header: a 32-bit word count.
  - Body: the instruction words.
- Assembles 32-bit words, writes them to consecutive word addresses from 0, and holds the CPU until the image is loaded.
- Sits between the host/debug byte source and the IF-stage instruction memory.

---
 rtl/instr_mem_loader_if.sv | 26 ++
 rtl/instr_mem_loader.sv | 182 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus for instr_mem_loader.
// slave: the loader (consumes bytes, drives the memory write port).
// master: the byte source / memory side.
interface instr_mem_loader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 1024
);
  localparam int unsigned LOGSIZE = $clog2(SIZE);

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [WIDTH-1:0]   instr_in;
  logic [LOGSIZE+1:0] wr_addr;
  logic               wr_en;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, instr_in, wr_addr, wr_en
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, instr_in, wr_addr, wr_en
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: parses a little-endian byte stream
// (32-bit word count followed by the words), writes words to consecutive
// word addresses from 0 and holds the CPU until the image is in memory.
// Optional: define LOADER_CHECKSUM_EN to require a trailing 32-bit sum of
// all data words before the load is declared done.
module instr_mem_loader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  instr_mem_loader_if.slave  bus,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);
  localparam int unsigned LOGSIZE = $clog2(SIZE);
  localparam int unsigned AW      = LOGSIZE + 2;
  localparam int unsigned IW      = LOGSIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t           r_state, w_state_d;
  logic [1:0]       r_byte_cnt, w_byte_cnt_d;
  logic [IW-1:0]    r_word_idx, w_word_idx_d;
  logic [31:0]      r_count, w_count_d;
  logic [WIDTH-9:0] r_shift, w_shift_d;
  logic [WIDTH-1:0] r_instr_in, w_instr_in_d;
  logic [AW-1:0]    r_wr_addr, w_wr_addr_d;
  logic             r_wr_en, w_wr_en_d;
  logic             r_byte_ready, w_byte_ready_d;
  logic             r_load_done, w_load_done_d;
  logic             r_load_err, w_load_err_d;
  logic             r_cpu_hold, w_cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      r_sum, w_sum_d;
`endif

  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_last;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_word_idx   <= '0;
      r_count      <= '0;
      r_shift      <= '0;
      r_instr_in   <= '0;
      r_wr_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_byte_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_cpu_hold   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_byte_cnt   <= w_byte_cnt_d;
      r_word_idx   <= w_word_idx_d;
      r_count      <= w_count_d;
      r_shift      <= w_shift_d;
      r_instr_in   <= w_instr_in_d;
      r_wr_addr    <= w_wr_addr_d;
      r_wr_en      <= w_wr_en_d;
      r_byte_ready <= w_byte_ready_d;
      r_load_done  <= w_load_done_d;
      r_load_err   <= w_load_err_d;
      r_cpu_hold   <= w_cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= w_sum_d;
`endif
    end
  end

  // Next-state, byte assembly and output decode; start overrides any byte
  always_comb begin
    w_word       = {bus.byte_in, r_shift};
    w_accept     = bus.byte_valid & r_byte_ready;
    w_last       = w_accept & (r_byte_cnt == 2'd3);
    w_state_d    = r_state;
    w_byte_cnt_d = r_byte_cnt;
    w_word_idx_d = r_word_idx;
    w_count_d    = r_count;
    w_shift_d    = r_shift;
    w_instr_in_d = r_instr_in;
    w_wr_addr_d  = r_wr_addr;
    w_wr_en_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_sum_d      = r_sum;
`endif

    if (start) begin
      w_state_d    = S_HDR;
      w_byte_cnt_d = '0;
      w_word_idx_d = '0;
      w_count_d    = '0;
      w_shift_d    = '0;
`ifdef LOADER_CHECKSUM_EN
      w_sum_d      = '0;
`endif
    end else begin
      if (w_accept) begin
        w_shift_d    = w_word[WIDTH-1:8];
        w_byte_cnt_d = r_byte_cnt + 2'd1;
      end
      unique case (r_state)
        S_HDR: begin
          if (w_last) begin
            w_count_d = w_word;
            if (w_word == 32'd0) begin
              w_state_d = S_FIN;
            end else if (w_word > 32'(SIZE)) begin
              w_state_d = S_ERR;
            end else begin
              w_state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_last) begin
            w_instr_in_d = w_word;
            w_wr_addr_d  = {r_word_idx[LOGSIZE-1:0], 2'b00};
            w_wr_en_d    = 1'b1;
            w_word_idx_d = r_word_idx + IW'(1);
`ifdef LOADER_CHECKSUM_EN
            w_sum_d      = r_sum + w_word;
`endif
            if ((32'(r_word_idx) + 32'd1) == r_count) begin
              w_state_d = S_FIN;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_last) begin
            w_state_d = (w_word == r_sum) ? S_DONE : S_ERR;
          end
        end
`endif
        default: ;
      endcase
    end

    w_byte_ready_d = (w_state_d == S_HDR) || (w_state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (w_state_d == S_CSUM)
`endif
                     ;
    w_load_done_d  = (w_state_d == S_DONE);
    w_load_err_d   = (w_state_d == S_ERR);
    w_cpu_hold_d   = (w_state_d != S_DONE);
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.instr_in   = r_instr_in;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_en      = r_wr_en;
  assign cpu_hold       = r_cpu_hold;
  assign load_done      = r_load_done;
  assign load_err       = r_load_err;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned SIZE  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, load_done, load_err;

  int n_vec  = 0;
  int n_miss = 0;

  // write log captured from the memory port
  int          n_wr = 0;
  logic [31:0] wr_a [32];
  logic [31:0] wr_d [32];
  int          wr_base;

  instr_mem_loader_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  instr_mem_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_a[n_wr % 32] = 32'(bus.wr_addr);
      wr_d[n_wr % 32] = bus.instr_in;
      n_wr = n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h5A;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"},  bus.instr_in,          32'd0);
    check({tag, "_addr"},   32'(bus.wr_addr),      32'd0);
    check({tag, "_wr_en"},  32'(bus.wr_en),        32'd0);
    check({tag, "_ready"},  32'(bus.byte_ready),   32'd0);
    check({tag, "_done"},   32'(load_done),        32'd0);
    check({tag, "_err"},    32'(load_err),         32'd0);
    check({tag, "_hold"},   32'(cpu_hold),         32'd1);
  endtask

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // reset values
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("idle_ready", 32'(bus.byte_ready), 32'd0);

    // basic two-word load
    wr_base = n_wr;
    pulse_start();
    check("hdr_ready", 32'(bus.byte_ready), 32'd1);
    check("hdr_hold",  32'(cpu_hold),       32'd1);
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0050_0093);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0050_00A6);
`else
    check("final_wr_en", 32'(bus.wr_en), 32'd1);
`endif
    check("basic_done",  32'(load_done),      32'd1);
    check("basic_hold",  32'(cpu_hold),       32'd0);
    check("basic_ready", 32'(bus.byte_ready), 32'd0);
    check("basic_err",   32'(load_err),       32'd0);
    @(negedge clk);
    check("wr_en_pulse", 32'(bus.wr_en), 32'd0);
    check("basic_nwr", 32'(n_wr - wr_base), 32'd2);
    check("basic_a0", wr_a[wr_base % 32],       32'h000);
    check("basic_d0", wr_d[wr_base % 32],       32'h0000_0013);
    check("basic_a1", wr_a[(wr_base + 1) % 32], 32'h004);
    check("basic_d1", wr_d[(wr_base + 1) % 32], 32'h0050_0093);

    // empty image
    wr_base = n_wr;
    pulse_start();
    check("restart_done_clr", 32'(load_done), 32'd0);
    send_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("empty_csum_ready", 32'(bus.byte_ready), 32'd1);
    send_word(32'd0);
`endif
    idle(2);
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_hold", 32'(cpu_hold),  32'd0);
    check("empty_nwr",  32'(n_wr - wr_base), 32'd0);

    // oversize count
    wr_base = n_wr;
    pulse_start();
    send_word(32'd1025);
    idle(2);
    check("over_err",   32'(load_err),       32'd1);
    check("over_hold",  32'(cpu_hold),       32'd1);
    check("over_ready", 32'(bus.byte_ready), 32'd0);
    check("over_done",  32'(load_done),      32'd0);
    check("over_nwr",   32'(n_wr - wr_base), 32'd0);
    pulse_start();
    check("over_restart_ready", 32'(bus.byte_ready), 32'd1);
    check("over_restart_err",   32'(load_err),       32'd0);

    // stalled stream, valid pattern 1-0-0-1-0-1-1 across the data word
    wr_base = n_wr;
    send_word(32'd1);
    send_byte(8'hEF);
    idle(2);
    send_byte(8'hBE);
    idle(1);
    send_byte(8'hAD);
    send_byte(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hDEAD_BEEF);
`endif
    idle(2);
    check("stall_nwr",  32'(n_wr - wr_base), 32'd1);
    check("stall_a0",   wr_a[wr_base % 32],  32'h000);
    check("stall_d0",   wr_d[wr_base % 32],  32'hDEAD_BEEF);
    check("stall_done", 32'(load_done),      32'd1);

    // reset after 6 accepted bytes
    pulse_start();
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // abort during DATA; start coincides with an offered byte that must be dropped
    wr_base = n_wr;
    pulse_start();
    send_word(32'd2);
    send_word(32'h1111_1111);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.byte_in    = 8'hFF;
    bus.byte_valid = 1'b1;
    pulse_start();
    bus.byte_valid = 1'b0;
    check("abort_wr_en", 32'(bus.wr_en), 32'd0);
    send_word(32'd1);
    send_word(32'h2222_2222);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h2222_2222);
`endif
    idle(2);
    check("abort_nwr",  32'(n_wr - wr_base),          32'd2);
    check("abort_a0",   wr_a[wr_base % 32],           32'h000);
    check("abort_d0",   wr_d[wr_base % 32],           32'h1111_1111);
    check("abort_a1",   wr_a[(wr_base + 1) % 32],     32'h000);
    check("abort_d1",   wr_d[(wr_base + 1) % 32],     32'h2222_2222);
    check("abort_done", 32'(load_done),               32'd1);

`ifdef LOADER_CHECKSUM_EN
    // checksum match and mismatch
    pulse_start();
    send_word(32'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    idle(1);
    check("csum_ok_done", 32'(load_done), 32'd1);
    check("csum_ok_err",  32'(load_err),  32'd0);
    pulse_start();
    send_word(32'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h4);
    idle(1);
    check("csum_bad_err",  32'(load_err),  32'd1);
    check("csum_bad_hold", 32'(cpu_hold),  32'd1);
    check("csum_bad_done", 32'(load_done), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
